// File: rtl/pass_keeper_decoder.sv
// Purpose : iterative Pass-Keeper decryption core, one inverse round per clock
//           with the key schedule walked backwards from a boot-time final key.
// Latency : boot_done rises ROUNDS+1 edges after reset release; a request
//           sampled at edge E completes (done, password) at edge E+ROUNDS.
// Backpr. : none; go is honoured only in READY, ignored otherwise, never queued.
//
// Ports:
//   clk           single clock, all state on the rising edge
//   rst           synchronous active-high reset, aborts any request in flight
//   go            request strobe, sampled only while READY
//   master_key    128-bit key, captured on the first edge after rst deasserts
//   account       128-bit tweak, captured with go
//   password_enc  128-bit ciphertext, captured with go
//   password      recovered plaintext, held until the next completion
//   done          one-cycle pulse marking password valid
//   boot_done     high once the final round key is available, low after rst

module pass_keeper_decoder #(
    parameter int ROUNDS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [127:0] master_key,
    input  logic [127:0] account,
    input  logic [127:0] password_enc,
    output logic [127:0] password,
    output logic         done,
    output logic         boot_done
);

    typedef enum logic [1:0] {
        RESET_LOAD = 2'd0,
        BOOT       = 2'd1,
        READY      = 2'd2,
        RUN        = 2'd3
    } state_t;

    // Index of the last round. With ROUNDS = 256 this is 255 and the 8-bit
    // counter covers 255..0 exactly.
    localparam logic [7:0] LAST = 8'(ROUNDS - 1);

    state_t       state;
    logic [7:0]   cnt;
    logic [127:0] kreg;
    logic [127:0] kfinal;
    logic [127:0] s;
    logic [127:0] acc;

    // Combinational round helpers.
    logic [127:0] k_fwd;    // next key in the forward schedule (BOOT)
    logic [127:0] k_prev;   // previous key in the schedule (RUN)
    logic [127:0] s_next;   // state after one inverse round with k_prev

    function automatic logic [127:0] rotl1(input logic [127:0] x);
        return {x[126:0], x[127]};
    endfunction

    function automatic logic [127:0] rotr1(input logic [127:0] x);
        return {x[0], x[127:1]};
    endfunction

    function automatic logic [127:0] rotr7(input logic [127:0] x);
        return {x[6:0], x[127:7]};
    endfunction

    always_comb begin
        k_fwd  = '0;
        k_prev = '0;
        s_next = '0;
        // Forward step: k(i+1) = rotl(k(i),1) ^ RC(i), RC(i) = cnt in the low byte.
        k_fwd  = rotl1(kreg) ^ {120'b0, cnt};
        // Inverse step: kreg holds k(cnt+1), recover k(cnt).
        k_prev = rotr1(kreg ^ {120'b0, cnt});
        // Undo the encryption round: subtract the low key half, rotate back,
        // then strip the key and tweak.
        s_next = rotr7(s - {64'b0, k_prev[63:0]}) ^ k_prev ^ acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RESET_LOAD;
            cnt       <= '0;
            kreg      <= '0;
            kfinal    <= '0;
            s         <= '0;
            acc       <= '0;
            password  <= '0;
            done      <= 1'b0;
            boot_done <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless RUN completes again below.
            done <= 1'b0;
            case (state)
                RESET_LOAD: begin
                    kreg  <= master_key;
                    cnt   <= '0;
                    state <= BOOT;
                end

                BOOT: begin
                    kreg <= k_fwd;
                    cnt  <= cnt + 8'd1;
                    if (cnt == LAST) begin
                        // k_fwd is k(ROUNDS): the starting point of every
                        // backwards key walk.
                        kfinal    <= k_fwd;
                        boot_done <= 1'b1;
                        state     <= READY;
                    end
                end

                READY: begin
                    if (go) begin
                        s     <= password_enc;
                        acc   <= account;
                        kreg  <= kfinal;
                        cnt   <= LAST;
                        state <= RUN;
                    end
                end

                RUN: begin
                    s    <= s_next;
                    kreg <= k_prev;
                    if (cnt == 8'd0) begin
                        password <= s_next;
                        done     <= 1'b1;
                        state    <= READY;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                default: state <= RESET_LOAD;
            endcase
        end
    end

endmodule
